// File: rtl/mlp_vec_feeder.sv
// mlp_vec_feeder: operand sequencer for a 4-lane 8-bit dot-product MAC chain.
//
// It accepts a stream of (activation, weight) byte pairs and packs each group of
// four pairs into the 32-bit a/b operand words of the chain. The running
// accumulator drives the chain's sum0 input, and the chain output is captured
// once per group. After len groups, the 32-bit dot product is returned on a
// valid/ready result port.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i, len_i       begin a vector of len_i groups (sampled in idle only)
//   busy_o               high whenever the feeder is not idle
//   in_valid_i/ready_o   byte-pair handshake; in_a_i / in_b_i carry the bytes
//   dp_sum0_o/a_o/b_o    operands to the MAC chain (lane k = bits [8k+7:8k])
//   dp_out_i             combinational chain result
//   res_valid_o/ready_i  result handshake; res_data_o holds the dot product
module mlp_vec_feeder #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [7:0]       in_a_i,
    input  logic [7:0]       in_b_i,
    output logic [WIDTH-1:0] dp_sum0_o,
    output logic [WIDTH-1:0] dp_a_o,
    output logic [WIDTH-1:0] dp_b_o,
    input  logic [WIDTH-1:0] dp_out_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o
);

    typedef enum logic [1:0] {StIdle, StFill, StAcc, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] pack_a_q;
    logic [WIDTH-1:0] pack_b_q;
    logic [1:0]       lane_q;
    logic [LEN_W-1:0] grp_q;
    logic [LEN_W-1:0] len_q;
    logic             busy_q;
    logic             in_ready_q;
    logic             res_valid_q;

    // The status flags are registered alongside the state, so none of them ever
    // depends combinationally on an input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            pack_a_q    <= '0;
            pack_b_q    <= '0;
            lane_q      <= '0;
            grp_q       <= '0;
            len_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        acc_q  <= '0;
                        lane_q <= '0;
                        grp_q  <= '0;
                        len_q  <= len_i;
                        busy_q <= 1'b1;
                        if (len_i != '0) begin
                            state_q    <= StFill;
                            in_ready_q <= 1'b1;
                        end else begin
                            // An empty vector reports a zero result immediately.
                            state_q     <= StDone;
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                StFill: begin
                    if (in_valid_i) begin
                        pack_a_q[{lane_q, 3'b000} +: 8] <= in_a_i;
                        pack_b_q[{lane_q, 3'b000} +: 8] <= in_b_i;
                        lane_q <= lane_q + 2'd1;  // wraps to 0 after lane 3
                        if (lane_q == 2'd3) begin
                            state_q    <= StAcc;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                StAcc: begin
                    acc_q <= dp_out_i;
                    grp_q <= grp_q + LEN_W'(1);
                    if (grp_q + LEN_W'(1) == len_q) begin
                        state_q     <= StDone;
                        res_valid_q <= 1'b1;
                    end else begin
                        state_q    <= StFill;
                        in_ready_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (res_ready_i) begin
                        state_q     <= StIdle;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign in_ready_o  = in_ready_q;
    assign res_valid_o = res_valid_q;
    assign dp_sum0_o   = acc_q;
    assign dp_a_o      = pack_a_q;
    assign dp_b_o      = pack_b_q;
    assign res_data_o  = acc_q;

endmodule

// File: tb/tb_mlp_vec_feeder.sv
// Self-checking bench for mlp_vec_feeder. The 4-lane MAC chain is modelled
// combinationally here. Whole vectors come from a table with hand-computed
// results. Backpressure, ignored start and mid-vector reset get dedicated
// sequences.
module tb_mlp_vec_feeder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [31:0] dp_sum0;
    logic [31:0] dp_a;
    logic [31:0] dp_b;
    logic [31:0] dp_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    int n_tests = 0;
    int n_fail  = 0;

    mlp_vec_feeder #(.LEN_W(8), .WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .len_i       (len),
        .busy_o      (busy),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .dp_sum0_o   (dp_sum0),
        .dp_a_o      (dp_a),
        .dp_b_o      (dp_b),
        .dp_out_i    (dp_out),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data)
    );

    // MAC chain model: sum0 + sum of unsigned 8x8 lane products.
    assign dp_out = dp_sum0
                  + 32'(dp_a[7:0])   * 32'(dp_b[7:0])
                  + 32'(dp_a[15:8])  * 32'(dp_b[15:8])
                  + 32'(dp_a[23:16]) * 32'(dp_b[23:16])
                  + 32'(dp_a[31:24]) * 32'(dp_b[31:24]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  len;
        logic [63:0] a;    // byte j = j-th activation sent
        logic [63:0] b;
        logic [31:0] mid;  // accumulator after group 0
        logic [31:0] res;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        start = 1'b1;
        len   = v.len;
        tick();
        start = 1'b0;
        chk("busy after start", 32'(busy), 32'd1);
        if (v.len == 8'd0) begin
            chk("len0 res_valid at T+1", 32'(res_valid), 32'd1);
            chk("len0 in_ready", 32'(in_ready), 32'd0);
        end else begin
            chk("in_ready after start", 32'(in_ready), 32'd1);
            for (int g = 0; g < int'(v.len); g++) begin
                for (int k = 0; k < 4; k++) begin
                    in_valid = 1'b1;
                    in_a = v.a[8*(4*g+k) +: 8];
                    in_b = v.b[8*(4*g+k) +: 8];
                    tick();
                end
                in_valid = 1'b0;
                chk("acc in_ready", 32'(in_ready), 32'd0);
                chk("acc dp_a", dp_a, v.a[32*g +: 32]);
                chk("acc dp_b", dp_b, v.b[32*g +: 32]);
                chk("acc dp_sum0", dp_sum0, (g == 0) ? 32'd0 : v.mid);
                tick();
            end
            chk("res_valid at E+2", 32'(res_valid), 32'd1);
        end
        chk("res_data", res_data, v.res);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("idle after result busy", 32'(busy), 32'd0);
        chk("idle after result res_valid", 32'(res_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{len: 8'd1, a: 64'h0000_0000_0403_0201, b: 64'h0000_0000_0807_0605,
                    mid: 32'd70, res: 32'd70};
        vecs[1] = '{len: 8'd2, a: 64'hFFFF_FFFF_0403_0201, b: 64'hFFFF_FFFF_0807_0605,
                    mid: 32'd70, res: 32'd260170};
        vecs[2] = '{len: 8'd0, a: 64'h0, b: 64'h0, mid: 32'd0, res: 32'd0};
        vecs[3] = '{len: 8'd1, a: 64'h0000_0000_FFFF_FFFF, b: 64'h0000_0000_FFFF_FFFF,
                    mid: 32'd260100, res: 32'd260100};
        vecs[4] = '{len: 8'd2, a: 64'h0202_0202_281E_140A, b: 64'h0303_0303_0101_0101,
                    mid: 32'd100, res: 32'd124};

        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; res_ready = 1'b0;
        tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset res_valid", 32'(res_valid), 32'd0);
        chk("reset res_data", res_data, 32'd0);
        chk("reset dp_a", dp_a, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_vec(i);

        // Backpressure on both sides, plus start pulses that must be ignored.
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int gap = 0; gap <= k % 3; gap++) begin
                start = (k == 1);  // len=0 request while filling
                len   = 8'd0;
                tick();
                chk("fill gap in_ready", 32'(in_ready), 32'd1);
            end
            start = 1'b0;
            send(8'(k + 1), 8'(k + 5));
        end
        chk("bp acc dp_a", dp_a, 32'h0403_0201);
        tick();
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("stall res_valid", 32'(res_valid), 32'd1);
            chk("stall res_data", res_data, 32'd70);
            tick();
            start = 1'b0;
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp idle after handshake", 32'(busy), 32'd0);
        tick();
        chk("no stray vector", 32'(busy), 32'd0);

        // Reset in the middle of the second group.
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) send(8'(k + 1), 8'(k + 5));
        tick();  // ACC
        send(8'd9, 8'd9);
        send(8'd9, 8'd9);
        chk("pre-reset dp_sum0", dp_sum0, 32'd70);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset in_ready", 32'(in_ready), 32'd0);
        chk("mid reset res_data", res_data, 32'd0);
        chk("mid reset dp_sum0", dp_sum0, 32'd0);
        chk("mid reset dp_a", dp_a, 32'd0);
        chk("mid reset dp_b", dp_b, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("reset res_valid", 32'(res_valid), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("post reset res_valid", 32'(res_valid), 32'd0);
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
